// File: rtl/tournament_bpu.sv
// Tournament branch direction predictor: local PHT, gshare-style global PHT
// and a per-PC chooser, with resolved-outcome training and prediction stats.
module tournament_bpu #(
    parameter int MODE    = 2,
    parameter int IDX_W   = 11,
    parameter int HIST_W  = 11,
    parameter int CTR_W   = 2,
    parameter int SEL_W   = 2,
    parameter int STATS_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_lookup_valid,
    input  logic [31:0]        i_lookup_pc,
    output logic               o_pred_taken,
    output logic [CTR_W-1:0]   o_pred_local_ctr,
    output logic [CTR_W-1:0]   o_pred_global_ctr,
    output logic [HIST_W-1:0]  o_pred_hist,
    input  logic               i_upd_valid,
    input  logic [31:0]        i_upd_pc,
    input  logic               i_upd_is_branch,
    input  logic               i_upd_is_jump,
    input  logic               i_upd_taken,
    input  logic               i_upd_pred_taken,
    input  logic [CTR_W-1:0]   i_upd_local_ctr,
    input  logic [CTR_W-1:0]   i_upd_global_ctr,
    input  logic [HIST_W-1:0]  i_upd_hist,
    output logic               o_upd_mispredict,
    input  logic               i_stat_clear,
    output logic [STATS_W-1:0] o_stat_branches,
    output logic [STATS_W-1:0] o_stat_correct,
    output logic [STATS_W-1:0] o_stat_mispredicts
);
    localparam int N = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [SEL_W-1:0] SEL_INIT = {1'b0, {(SEL_W-1){1'b1}}};

    logic [HIST_W-1:0]  r_hist;
    logic [STATS_W-1:0] r_br;
    logic [STATS_W-1:0] r_ok;
    logic [STATS_W-1:0] r_mis;
    logic [IDX_W-1:0]   w_lk_li;
    logic [IDX_W-1:0]   w_lk_gi;
    logic [IDX_W-1:0]   w_up_li;
    logic [IDX_W-1:0]   w_up_gi;
    logic [CTR_W-1:0]   w_loc_rd;
    logic [CTR_W-1:0]   w_glb_rd;
    logic [SEL_W-1:0]   w_sel_rd;
    logic               w_event;
    logic               w_t;
    logic               w_br;
    logic               w_pred;
    logic               w_unused;

    function automatic logic [CTR_W-1:0] f_ctr(input logic [CTR_W-1:0] c,
                                               input logic up);
        if (up) return (&c) ? c : c + CTR_W'(1);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    function automatic logic [SEL_W-1:0] f_sel(input logic [SEL_W-1:0] c,
                                               input logic up);
        if (up) return (&c) ? c : c + SEL_W'(1);
        return (c == '0) ? c : c - SEL_W'(1);
    endfunction

    assign w_lk_li = i_lookup_pc[IDX_W+1:2];
    assign w_lk_gi = w_lk_li ^ IDX_W'(r_hist);
    assign w_up_li = i_upd_pc[IDX_W+1:2];
    assign w_up_gi = w_up_li ^ IDX_W'(i_upd_hist);
    assign w_event = i_upd_valid & (i_upd_is_branch | i_upd_is_jump);
    assign w_t     = i_upd_taken | i_upd_is_jump;
    assign w_br    = i_upd_valid & i_upd_is_branch;

    assign w_unused = ^{i_lookup_pc[31:IDX_W+2], i_lookup_pc[1:0],
                        i_upd_pc[31:IDX_W+2], i_upd_pc[1:0],
                        w_lk_gi, w_up_gi, i_upd_local_ctr,
                        i_upd_global_ctr, i_upd_hist};

    generate
        if (MODE != 1) begin : g_local
            logic [CTR_W-1:0] r_local [N];
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < N; i++) r_local[i] <= CTR_INIT;
                end else if (w_event) begin
                    r_local[w_up_li] <= f_ctr(i_upd_local_ctr, w_t);
                end
            end
            assign w_loc_rd = r_local[w_lk_li];
        end else begin : g_no_local
            assign w_loc_rd = CTR_INIT;
        end

        if (MODE != 0) begin : g_global
            logic [CTR_W-1:0] r_global [N];
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < N; i++) r_global[i] <= CTR_INIT;
                end else if (w_event) begin
                    r_global[w_up_gi] <= f_ctr(i_upd_global_ctr, w_t);
                end
            end
            assign w_glb_rd = r_global[w_lk_gi];
        end else begin : g_no_global
            assign w_glb_rd = CTR_INIT;
        end

        // Chooser trains only when the two snapshots disagreed.
        if (MODE == 2) begin : g_chooser
            logic [SEL_W-1:0] r_sel [N];
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < N; i++) r_sel[i] <= SEL_INIT;
                end else if (w_event &&
                             (i_upd_local_ctr[CTR_W-1] !=
                              i_upd_global_ctr[CTR_W-1])) begin
                    r_sel[w_up_li] <= f_sel(r_sel[w_up_li],
                                            i_upd_global_ctr[CTR_W-1] == w_t);
                end
            end
            assign w_sel_rd = r_sel[w_lk_li];
        end else begin : g_no_chooser
            assign w_sel_rd = SEL_INIT;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= '0;
        end else if (w_event) begin
            r_hist <= HIST_W'({r_hist, w_t});
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_stat_clear) begin
            r_br  <= '0;
            r_ok  <= '0;
            r_mis <= '0;
        end else if (w_br) begin
            r_br <= r_br + STATS_W'(1);
            if (i_upd_pred_taken == i_upd_taken) r_ok <= r_ok + STATS_W'(1);
            else r_mis <= r_mis + STATS_W'(1);
        end
    end

    always_comb begin
        w_pred = w_loc_rd[CTR_W-1];
        if (MODE == 1) begin
            w_pred = w_glb_rd[CTR_W-1];
        end else if (MODE == 2) begin
            w_pred = w_sel_rd[SEL_W-1] ? w_glb_rd[CTR_W-1]
                                       : w_loc_rd[CTR_W-1];
        end
    end

    assign o_pred_taken       = i_lookup_valid & w_pred;
    assign o_pred_local_ctr   = w_loc_rd;
    assign o_pred_global_ctr  = w_glb_rd;
    assign o_pred_hist        = r_hist;
    assign o_upd_mispredict   = w_br & (i_upd_pred_taken != i_upd_taken);
    assign o_stat_branches    = r_br;
    assign o_stat_correct     = r_ok;
    assign o_stat_mispredicts = r_mis;
endmodule
